// File: rtl/am_lock_rx.sv
// am_lock_rx: per-lane alignment-marker search/confirm/lock FSMs with a one-cycle registered data path.
// Defining AM_ERR_CNT_EN adds am_err_cnt_o, a per-lane saturating count of expected-AM mismatches while locked.
module am_lock_rx #(
    parameter int LANE_N  = 4,
    parameter int BLOCK_W = 66,
    parameter int AM_GAP  = 16383
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_i,
    input  logic [LANE_N-1:0]          lock_i,
    input  logic [LANE_N*BLOCK_W-1:0]  block_i,
    output logic                       valid_o,
    output logic [LANE_N*BLOCK_W-1:0]  block_o,
    output logic [LANE_N-1:0]          am_o,
    output logic [LANE_N*LANE_N-1:0]   lane_o,
    output logic [LANE_N-1:0]          am_lock_o
`ifdef AM_ERR_CNT_EN
    ,
    output logic [LANE_N*8-1:0]        am_err_cnt_o
`endif
);

    localparam int ID_W  = (LANE_N > 1) ? $clog2(LANE_N) : 1;
    localparam int CNT_W = (AM_GAP > 0) ? $clog2(AM_GAP + 1) : 1;
    localparam logic [CNT_W-1:0] GAP = CNT_W'(AM_GAP);

    typedef enum logic [1:0] {
        SEARCH,
        CONFIRM,
        LOCK
    } state_t;

    // {M0,M1,M2} per logical lane
    function automatic logic [23:0] marker(input int id);
        case (id)
            0:       marker = 24'h907647;
            1:       marker = 24'hF0C4E6;
            2:       marker = 24'hC5659B;
            3:       marker = 24'hA2793D;
            default: marker = 24'h000000;
        endcase
    endfunction

    // lo = block[25:2] (M0 in the low byte), hi = block[57:34] (M4 in the low byte)
    function automatic logic is_am(input logic [1:0] hdr, input logic [23:0] lo,
                                   input logic [23:0] hi, input int id);
        logic [23:0] m;
        m = marker(id);
        return (hdr == 2'b01) && ({lo[7:0], lo[15:8], lo[23:16]} == m)
            && ({hi[7:0], hi[15:8], hi[23:16]} == ~m);
    endfunction

    state_t            state_q [LANE_N];
    state_t            state_d [LANE_N];
    logic [ID_W-1:0]   id_q    [LANE_N];
    logic [ID_W-1:0]   id_d    [LANE_N];
    logic [CNT_W-1:0]  cnt_q   [LANE_N];
    logic [CNT_W-1:0]  cnt_d   [LANE_N];
    logic [1:0]        mis_q   [LANE_N];
    logic [1:0]        mis_d   [LANE_N];
    logic [ID_W-1:0]   hit_id  [LANE_N];
    logic [LANE_N-1:0] hit_any;
    logic [LANE_N-1:0] hit_own;
    logic [LANE_N-1:0] am_d;

    // Descending search so the lowest matching logical id wins.
    always_comb begin
        for (int x = 0; x < LANE_N; x++) begin
            hit_any[x] = 1'b0;
            hit_own[x] = 1'b0;
            hit_id[x]  = '0;
            for (int k = LANE_N - 1; k >= 0; k--) begin
                if (is_am(block_i[x*BLOCK_W +: 2], block_i[x*BLOCK_W+2 +: 24],
                          block_i[x*BLOCK_W+34 +: 24], k)) begin
                    hit_any[x] = 1'b1;
                    hit_id[x]  = ID_W'(k);
                    if (ID_W'(k) == id_q[x]) hit_own[x] = 1'b1;
                end
            end
        end
    end

    // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned (no latch).
    always_comb begin
        for (int x = 0; x < LANE_N; x++) begin
            state_d[x] = state_q[x];
            id_d[x]    = id_q[x];
            cnt_d[x]   = cnt_q[x];
            mis_d[x]   = mis_q[x];
            am_d[x]    = 1'b0;
            if (valid_i) begin
                case (state_q[x])
                    SEARCH: begin
                        if (hit_any[x]) begin
                            id_d[x]    = hit_id[x];
                            cnt_d[x]   = '0;
                            state_d[x] = CONFIRM;
                        end
                    end
                    CONFIRM: begin
                        if (cnt_q[x] == GAP) begin
                            cnt_d[x]   = '0;
                            mis_d[x]   = '0;
                            state_d[x] = hit_own[x] ? LOCK : SEARCH;
                        end else begin
                            cnt_d[x] = cnt_q[x] + CNT_W'(1);
                        end
                    end
                    LOCK: begin
                        if (cnt_q[x] == GAP) begin
                            cnt_d[x] = '0;
                            if (hit_own[x]) begin
                                mis_d[x] = '0;
                                am_d[x]  = 1'b1;
                            end else if (mis_q[x] == 2'd3) begin
                                mis_d[x]   = '0;
                                state_d[x] = SEARCH;
                            end else begin
                                mis_d[x] = mis_q[x] + 2'd1;
                            end
                        end else begin
                            cnt_d[x] = cnt_q[x] + CNT_W'(1);
                        end
                    end
                    default: state_d[x] = SEARCH;
                endcase
            end
            // Loss of block lock overrides everything, even on idle cycles.
            if (!lock_i[x]) begin
                state_d[x] = SEARCH;
                mis_d[x]   = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_o <= 1'b0;
            block_o <= '0;
            am_o    <= '0;
            for (int x = 0; x < LANE_N; x++) begin
                state_q[x] <= SEARCH;
                id_q[x]    <= '0;
                cnt_q[x]   <= '0;
                mis_q[x]   <= '0;
            end
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                block_o <= block_i;
                am_o    <= am_d;
            end
            for (int x = 0; x < LANE_N; x++) begin
                state_q[x] <= state_d[x];
                id_q[x]    <= id_d[x];
                cnt_q[x]   <= cnt_d[x];
                mis_q[x]   <= mis_d[x];
            end
        end
    end

    always_comb begin
        am_lock_o = '0;
        lane_o    = '0;
        for (int x = 0; x < LANE_N; x++) begin
            am_lock_o[x] = (state_q[x] == LOCK);
            if (state_q[x] == LOCK) lane_o[x*LANE_N +: LANE_N] = LANE_N'(1) << id_q[x];
        end
    end

`ifdef AM_ERR_CNT_EN
    logic [LANE_N-1:0] miss;
    logic [7:0]        err_q [LANE_N];

    always_comb begin
        for (int x = 0; x < LANE_N; x++) begin
            miss[x] = valid_i && (state_q[x] == LOCK) && (cnt_q[x] == GAP) && !hit_own[x];
        end
    end

    always_ff @(posedge clk) begin
        for (int x = 0; x < LANE_N; x++) begin
            if (reset) begin
                err_q[x] <= '0;
            end else if (miss[x] && (err_q[x] != 8'hFF)) begin
                err_q[x] <= err_q[x] + 8'd1;
            end
        end
    end

    always_comb begin
        am_err_cnt_o = '0;
        for (int x = 0; x < LANE_N; x++) am_err_cnt_o[x*8 +: 8] = err_q[x];
    end
`endif

endmodule

// File: tb/tb_am_lock_rx.sv
// Directed bench for am_lock_rx (AM_GAP=15): scoreboard of expected outputs per driven cycle.
module tb_am_lock_rx;

    localparam int LANE_N  = 4;
    localparam int BLOCK_W = 66;
    localparam int AM_GAP  = 15;
    localparam int PERIOD  = AM_GAP + 1;
    localparam int W       = LANE_N * BLOCK_W;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       valid_i = 1'b0;
    logic [LANE_N-1:0]          lock_i = '0;
    logic [W-1:0]               block_i = '0;
    logic                       valid_o;
    logic [W-1:0]               block_o;
    logic [LANE_N-1:0]          am_o;
    logic [LANE_N*LANE_N-1:0]   lane_o;
    logic [LANE_N-1:0]          am_lock_o;
`ifdef AM_ERR_CNT_EN
    logic [LANE_N*8-1:0]        am_err_cnt_o;
`endif

    always #5 clk = ~clk;

    am_lock_rx #(.LANE_N(LANE_N), .BLOCK_W(BLOCK_W), .AM_GAP(AM_GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .lock_i    (lock_i),
        .block_i   (block_i),
        .valid_o   (valid_o),
        .block_o   (block_o),
        .am_o      (am_o),
        .lane_o    (lane_o),
        .am_lock_o (am_lock_o)
`ifdef AM_ERR_CNT_EN
        ,
        .am_err_cnt_o (am_err_cnt_o)
`endif
    );

    typedef struct {
        logic              valid;
        logic [W-1:0]      blk;
        logic [LANE_N-1:0] am;
        logic [LANE_N-1:0] lock;
    } exp_t;

    exp_t              sb[$];
    int                vectors = 0;
    int                miscompares = 0;
    string             phase = "reset";
    logic [W-1:0]      last_blk = '0;
    logic [LANE_N-1:0] last_am = '0;

    // Physical lane x carries logical lane log_of(x).
    function automatic int log_of(input int x);
        case (x)
            0: return 2;
            1: return 0;
            2: return 3;
            default: return 1;
        endcase
    endfunction

    function automatic logic [23:0] marker(input int id);
        case (id)
            0: return 24'h907647;
            1: return 24'hF0C4E6;
            2: return 24'hC5659B;
            default: return 24'hA2793D;
        endcase
    endfunction

    function automatic logic [BLOCK_W-1:0] make_am(input int id, input logic bad);
        logic [23:0] m;
        logic [7:0]  m1;
        m  = marker(id);
        m1 = m[15:8] ^ (bad ? 8'h10 : 8'h00);
        return {8'($urandom), ~m[7:0], ~m[15:8], ~m[23:16], 8'($urandom), m[7:0], m1, m[23:16], 2'b01};
    endfunction

    function automatic logic [BLOCK_W-1:0] rand_data();
        return {$urandom, $urandom, 2'b10};
    endfunction

    function automatic logic [15:0] lane_of(input logic [3:0] lk);
        logic [15:0] r;
        r = '0;
        for (int x = 0; x < 4; x++) if (lk[x]) r[x*4 +: 4] = 4'(1 << log_of(x));
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s/%s got %h exp %h", phase, tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [3:0] lk, input logic [3:0] am_mask,
                        input logic [3:0] corrupt, input logic [3:0] exp_am, input logic [3:0] exp_lock);
        exp_t         e;
        logic [W-1:0] blk;
        for (int x = 0; x < LANE_N; x++)
            blk[x*BLOCK_W +: BLOCK_W] = am_mask[x] ? make_am(log_of(x), corrupt[x]) : rand_data();
        reset   = rst;
        valid_i = v;
        lock_i  = lk;
        block_i = blk;
        if (rst) begin
            e.valid = 1'b0;
            e.blk   = '0;
            e.am    = '0;
            e.lock  = '0;
        end else begin
            e.valid = v;
            e.blk   = v ? blk : last_blk;
            e.am    = v ? exp_am : last_am;
            e.lock  = exp_lock;
        end
        last_blk = e.blk;
        last_am  = e.am;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("valid_o",   W'(valid_o),   W'(e.valid));
        check("block_o",   block_o,       e.blk);
        check("am_o",      W'(am_o),      W'(e.am));
        check("am_lock_o", W'(am_lock_o), W'(e.lock));
        check("lane_o",    W'(lane_o),    W'(lane_of(e.lock)));
    endtask

    // One AM on every lane followed by AM_GAP data blocks.
    task automatic period(input logic [3:0] corrupt, input logic [3:0] exp_am, input logic [3:0] exp_lock);
        step(1'b0, 1'b1, 4'hF, 4'hF, corrupt, exp_am, exp_lock);
        repeat (PERIOD - 1) step(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, exp_lock);
    endtask

    initial begin
        phase = "reset";
        repeat (100) step(1'b1, 1'b1, 4'hF, 4'($urandom_range(0, 15)), 4'h0, 4'h0, 4'h0);

        phase = "acquire";
        repeat (5) step(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        period(4'h0, 4'h0, 4'h0);
        period(4'h0, 4'h0, 4'hF);
        period(4'h0, 4'hF, 4'hF);
        period(4'h0, 4'hF, 4'hF);

        phase = "mismatch3";
        repeat (3) period(4'h2, 4'hD, 4'hF);
        period(4'h0, 4'hF, 4'hF);

        phase = "mismatch4";
        repeat (3) period(4'h2, 4'hD, 4'hF);
        period(4'h2, 4'hD, 4'hD);
        period(4'h0, 4'hD, 4'hD);
        period(4'h0, 4'hD, 4'hF);
        period(4'h0, 4'hF, 4'hF);

        phase = "off_period_am";
        step(1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF);
        for (int p = 1; p < PERIOD; p++)
            step(1'b0, 1'b1, 4'hF, (p == 5) ? 4'hF : 4'h0, 4'h0, 4'h0, 4'hF);
        period(4'h0, 4'hF, 4'hF);

        phase = "valid_toggle";
        begin
            int pos = 0;
            int nvalid = 0;
            for (int i = 0; i < 2000 && nvalid < 4 * PERIOD; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    step(1'b0, 1'b1, 4'hF, (pos == 0) ? 4'hF : 4'h0, 4'h0, (pos == 0) ? 4'hF : 4'h0, 4'hF);
                    pos = (pos + 1) % PERIOD;
                    nvalid++;
                end else begin
                    step(1'b0, 1'b0, 4'hF, 4'($urandom_range(0, 15)), 4'h0, 4'h0, 4'hF);
                end
            end
        end

        phase = "lock_drop";
        step(1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF);
        step(1'b0, 1'b1, 4'hB, 4'h0, 4'h0, 4'h0, 4'hB);
        repeat (PERIOD - 2) step(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'hB);
        period(4'h0, 4'hB, 4'hB);
        period(4'h0, 4'hB, 4'hF);
        period(4'h0, 4'hF, 4'hF);

`ifdef AM_ERR_CNT_EN
        phase = "err_cnt";
        check("am_err_cnt_o", W'(am_err_cnt_o), W'(32'h0000_0700));
`endif

        phase = "reset_mid_lock";
        step(1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        repeat (3) step(1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);

`ifdef AM_ERR_CNT_EN
        phase = "err_cnt_sat";
        check("am_err_cnt_o", W'(am_err_cnt_o), W'(32'h0));
        period(4'h0, 4'h0, 4'h0);
        period(4'h0, 4'h0, 4'hF);
        repeat (75) begin
            repeat (3) period(4'h2, 4'hD, 4'hF);
            period(4'h2, 4'hD, 4'hD);
            period(4'h0, 4'hD, 4'hD);
            period(4'h0, 4'hD, 4'hF);
        end
        check("am_err_cnt_o", W'(am_err_cnt_o), W'(32'h0000_FF00));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
